// File: rtl/sync_scheduler_pkg.sv
// Shared constants for the sync strobe scheduler: FSM state encodings and trigger modes.
package sync_scheduler_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_TRIG  = 2'd3;

    localparam logic MODE_INT = 1'b0;
    localparam logic MODE_EXT = 1'b1;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser followed by a rising-edge detector; rise_o is a 1-cycle pulse.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/sync_scheduler.sv
// Sync strobe scheduler: internal periodic bursts or externally triggered strobes,
// with a guaranteed minimum spacing between o_sync rising edges.
module sync_scheduler
    import sync_scheduler_pkg::*;
#(
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned BURST_W    = 16,
    parameter int unsigned PULSE_W    = 4,
    parameter int unsigned MIN_PERIOD = 16
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic [CNT_W-1:0]   i_cfg_period,
    input  logic [BURST_W-1:0] i_cfg_count,
    input  logic               i_cfg_mode,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_ext_trig,
    output logic               o_sync,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_cfg_err,
    output logic [BURST_W-1:0] o_sync_num
);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [BURST_W-1:0] count_q, count_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [BURST_W-1:0] num_q, num_d;
    logic               sync_q, sync_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               trig_rise;
    logic               run_complete;
    logic               window_end;

    sync_edge_det u_trig_det (
        .clk_i  (sys_clk),
        .rst_ni (rst_n),
        .d_i    (i_ext_trig),
        .rise_o (trig_rise)
    );

    assign run_complete = (count_q != '0) && (num_q == count_q);
    // Internal mode waits out the period; external mode only the holdoff.
    assign window_end   = (mode_q == MODE_INT) ? (cyc_q == period_q - CNT_W'(1))
                                               : (cyc_q == CNT_W'(MIN_PERIOD - 1));

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        count_d  = count_q;
        mode_d   = mode_q;
        cyc_d    = cyc_q;
        num_d    = num_q;
        done_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_start && !i_stop) begin
                    period_d = i_cfg_period;
                    count_d  = i_cfg_count;
                    mode_d   = i_cfg_mode;
                    if (i_cfg_mode == MODE_INT && i_cfg_period < CNT_W'(MIN_PERIOD)) begin
                        err_d = 1'b1;
                    end else begin
                        num_d   = '0;
                        cyc_d   = '0;
                        state_d = (i_cfg_mode == MODE_INT) ? S_PULSE : S_TRIG;
                    end
                end
            end
            S_PULSE: begin
                if (cyc_q == '0) begin
                    num_d = num_q + BURST_W'(1);
                end
                cyc_d = cyc_q + CNT_W'(1);
                if (cyc_q == CNT_W'(PULSE_W - 1)) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cyc_d = cyc_q + CNT_W'(1);
                if (window_end) begin
                    if (run_complete) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (mode_q == MODE_INT) begin
                        state_d = S_PULSE;
                        cyc_d   = '0;
                    end else begin
                        state_d = S_TRIG;
                    end
                end
            end
            S_TRIG: begin
                if (trig_rise) begin
                    state_d = S_PULSE;
                    cyc_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort beats everything outside IDLE; the pulse count is preserved.
        if (i_stop && state_q != S_IDLE) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            num_d   = num_q;
        end
    end

    assign sync_d = (state_q == S_PULSE) && (state_d != S_IDLE);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            period_q <= '0;
            count_q  <= '0;
            mode_q   <= MODE_INT;
            cyc_q    <= '0;
            num_q    <= '0;
            sync_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            count_q  <= count_d;
            mode_q   <= mode_d;
            cyc_q    <= cyc_d;
            num_q    <= num_d;
            sync_q   <= sync_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign o_sync     = sync_q;
    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = done_q;
    assign o_cfg_err  = err_q;
    assign o_sync_num = num_q;

endmodule
